// File: rtl/dma_ctrl_if.sv
// Bus bundle for dma_ctrl: CPU-side register port plus the single-word request
// channel towards the DMA master. "master" is the sequencer view, "slave" the peer.
interface dma_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              reg_we;
  logic [4:0]        reg_addr;
  logic [31:0]       reg_wdata;
  logic [31:0]       reg_rdata;
  logic              mst_req;
  logic              mst_write;
  logic [ADDR_W-1:0] mst_addr;
  logic [31:0]       mst_wdata;
  logic [3:0]        mst_wstrb;
  logic              mst_ack;
  logic [31:0]       mst_rdata;
  logic              dma_irq;

  modport master (
    input  reg_we, reg_addr, reg_wdata, mst_ack, mst_rdata,
    output reg_rdata, mst_req, mst_write, mst_addr, mst_wdata, mst_wstrb, dma_irq
  );

  modport slave (
    output reg_we, reg_addr, reg_wdata, mst_ack, mst_rdata,
    input  reg_rdata, mst_req, mst_write, mst_addr, mst_wdata, mst_wstrb, dma_irq
  );
endinterface

// File: rtl/dma_ctrl.sv
// Register-programmed DMA sequencer: chunked read-then-write copy through a small FIFO.
// Optional DMA_ABORT_EN: a CTRL write with EN=0 during a transfer aborts after the in-flight ack.
//
// state | meaning
// IDLE  | registers writable, waiting for CTRL.EN=1
// RD    | issuing reads of the current chunk into the buffer
// WR    | draining the buffer into writes
// DONE  | transfer finished, irq asserted until CTRL.EN=0
module dma_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  dma_ctrl_if.master  bus
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN   = ~ADDR_W'(3);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              ctrl_en_q, ctrl_en_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [15:0]       rem_q, rem_d;
  logic [CW-1:0]     chunk_q, chunk_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic              req_q, req_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              irq_q, irq_d;
  logic              aborted_q, aborted_d;
`ifdef DMA_ABORT_EN
  logic              abort_pend_q, abort_pend_d;
`endif

  logic [DATA_W-1:0] buf_q [BUF_DEPTH];

  logic              ctrl_wr, src_wr, dst_wr, len_wr, wr_en;
  logic              acked, push, to_idle, abort_now, busy;
  logic [CW-1:0]     cnt_inc, cnt_dec;
  logic [PW-1:0]     rptr_nx;
  logic [15:0]       rem_dec;
  logic [31:0]       status;

  assign ctrl_wr = bus.reg_we && (bus.reg_addr == 5'h00);
  assign src_wr  = bus.reg_we && (bus.reg_addr == 5'h04);
  assign dst_wr  = bus.reg_we && (bus.reg_addr == 5'h08);
  assign len_wr  = bus.reg_we && (bus.reg_addr == 5'h0C);
  assign wr_en   = bus.reg_wdata[0];
  assign busy    = (state_q == S_RD) || (state_q == S_WR);
  assign acked   = bus.mst_ack && req_q && busy;

  assign cnt_inc = cnt_q + CW'(1);
  assign cnt_dec = cnt_q - CW'(1);
  assign rptr_nx = rptr_q + PW'(1);
  assign rem_dec = rem_q - 16'd1;

  function automatic logic [CW-1:0] chunk_of(input logic [15:0] r);
    return (r >= 16'(BUF_DEPTH)) ? DEPTH_C : r[CW-1:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    ctrl_en_d = ctrl_en_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    rem_d     = rem_q;
    chunk_d   = chunk_q;
    cnt_d     = cnt_q;
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    req_d     = req_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    aborted_d = aborted_q;
    push      = 1'b0;
    to_idle   = 1'b0;
    abort_now = 1'b0;
`ifdef DMA_ABORT_EN
    abort_pend_d = abort_pend_q;
`endif

    if (state_q == S_IDLE) begin
      if (src_wr) src_d = ADDR_W'(bus.reg_wdata) & ALIGN;
      if (dst_wr) dst_d = ADDR_W'(bus.reg_wdata) & ALIGN;
      if (len_wr) len_d = bus.reg_wdata[15:0];
    end

    case (state_q)
      S_IDLE: begin
        if (ctrl_wr) begin
          ctrl_en_d = wr_en;
          if (wr_en) begin
            src_ptr_d = src_q;
            dst_ptr_d = dst_q;
            rem_d     = len_q;
            chunk_d   = chunk_of(len_q);
            cnt_d     = '0;
            rptr_d    = '0;
            wptr_d    = '0;
            aborted_d = 1'b0;
            state_d   = (len_q == 16'd0) ? S_DONE : S_RD;
          end
        end
      end

      S_RD, S_WR: begin
`ifdef DMA_ABORT_EN
        if (ctrl_wr && !wr_en) begin
          abort_pend_d = 1'b1;
          ctrl_en_d    = 1'b0;
        end
        abort_now = abort_pend_q || (ctrl_wr && !wr_en);
`endif
        if (!req_q) begin
          // Only reachable in the launch cycle right after the start write.
          if (abort_now) begin
            to_idle = 1'b1;
          end else if (state_q == S_RD) begin
            req_d   = 1'b1;
            write_d = 1'b0;
            addr_d  = src_ptr_q;
          end else begin
            req_d   = 1'b1;
            write_d = 1'b1;
            addr_d  = dst_ptr_q;
            wdata_d = buf_q[rptr_q];
          end
        end else if (acked && (state_q == S_RD)) begin
          push      = 1'b1;
          src_ptr_d = src_ptr_q + STEP;
          wptr_d    = wptr_q + PW'(1);
          cnt_d     = cnt_inc;
          if (abort_now) begin
            to_idle = 1'b1;
          end else if (cnt_inc == chunk_q) begin
            state_d = S_WR;
            req_d   = 1'b1;
            write_d = 1'b1;
            addr_d  = dst_ptr_q;
            // A one-word chunk has its head word arriving on this very ack.
            wdata_d = (cnt_q == '0) ? bus.mst_rdata : buf_q[rptr_q];
          end else begin
            req_d   = 1'b1;
            write_d = 1'b0;
            addr_d  = src_ptr_q + STEP;
          end
        end else if (acked) begin
          rptr_d    = rptr_nx;
          cnt_d     = cnt_dec;
          dst_ptr_d = dst_ptr_q + STEP;
          rem_d     = rem_dec;
          if (abort_now) begin
            to_idle = 1'b1;
          end else if (cnt_dec != '0) begin
            req_d   = 1'b1;
            write_d = 1'b1;
            addr_d  = dst_ptr_q + STEP;
            wdata_d = buf_q[rptr_nx];
          end else if (rem_dec == 16'd0) begin
            state_d = S_DONE;
            req_d   = 1'b0;
            write_d = 1'b0;
          end else begin
            state_d = S_RD;
            chunk_d = chunk_of(rem_dec);
            req_d   = 1'b1;
            write_d = 1'b0;
            addr_d  = src_ptr_q;
          end
        end
      end

      S_DONE: begin
        if (ctrl_wr && !wr_en) begin
          ctrl_en_d = 1'b0;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (to_idle) begin
      state_d   = S_IDLE;
      req_d     = 1'b0;
      write_d   = 1'b0;
      aborted_d = 1'b1;
      cnt_d     = '0;
      rptr_d    = '0;
      wptr_d    = '0;
`ifdef DMA_ABORT_EN
      abort_pend_d = 1'b0;
`endif
    end

    // The start edge is excluded so a zero-length job still spends one cycle before irq.
    irq_d = (state_d == S_DONE) && (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ctrl_en_q <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      rem_q     <= '0;
      chunk_q   <= '0;
      cnt_q     <= '0;
      rptr_q    <= '0;
      wptr_q    <= '0;
      req_q     <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      irq_q     <= 1'b0;
      aborted_q <= 1'b0;
`ifdef DMA_ABORT_EN
      abort_pend_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ctrl_en_q <= ctrl_en_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      rem_q     <= rem_d;
      chunk_q   <= chunk_d;
      cnt_q     <= cnt_d;
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      req_q     <= req_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      irq_q     <= irq_d;
      aborted_q <= aborted_d;
`ifdef DMA_ABORT_EN
      abort_pend_q <= abort_pend_d;
`endif
    end
  end

  // Storage only; validity is tracked by the reset pointers and count.
  always_ff @(posedge clk) begin
    if (push) buf_q[wptr_q] <= bus.mst_rdata;
  end

  assign status = {16'h0, rem_q[7:0], 5'b0, aborted_q, irq_q, busy};

  always_comb begin
    case (bus.reg_addr)
      5'h00:   bus.reg_rdata = {31'h0, ctrl_en_q};
      5'h04:   bus.reg_rdata = 32'(src_q);
      5'h08:   bus.reg_rdata = 32'(dst_q);
      5'h0C:   bus.reg_rdata = {16'h0, len_q};
      5'h10:   bus.reg_rdata = status;
      default: bus.reg_rdata = 32'h0;
    endcase
  end

  assign bus.mst_req   = req_q;
  assign bus.mst_write = write_q;
  assign bus.mst_addr  = addr_q;
  assign bus.mst_wdata = wdata_q;
  assign bus.mst_wstrb = 4'hF;
  assign bus.dma_irq   = irq_q;

endmodule

// File: tb/tb_dma_ctrl.sv
// Bench for dma_ctrl: transaction-list model of the copy, a responding master that
// checks every acked request, plus directed register/irq/reset checks.
module tb_dma_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dma_ctrl_if #(.ADDR_W(32)) bus ();
  dma_ctrl #(.ADDR_W(32), .DATA_W(32), .BUF_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xact_t;

  xact_t exp_q[$];
  int    n_chk = 0, n_pass = 0;
  int    lat = 2, wcnt = 0, n_acks = 0;
  bit    gap_chk = 0, rem_chk = 0, started = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Expected bus transactions: chunks of min(rem,4) reads then the same words written.
  function automatic void plan(input logic [31:0] src, input logic [31:0] dst, input int len);
    logic [31:0] s, d;
    int rem, c;
    s = src & ~32'h3;
    d = dst & ~32'h3;
    rem = len;
    while (rem > 0) begin
      c = (rem < 4) ? rem : 4;
      for (int i = 0; i < c; i++) exp_q.push_back('{1'b0, s + 32'(4*i), 32'h0});
      for (int i = 0; i < c; i++) exp_q.push_back('{1'b1, d + 32'(4*i), mem_word(s + 32'(4*i))});
      s = s + 32'(4*c);
      d = d + 32'(4*c);
      rem = rem - c;
    end
  endfunction

  function automatic int writes_left();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].wr) n++;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", nm, act, exp);
  endtask

  // Responding master and per-cycle compare against the transaction model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        bus.mst_ack = 1'b0;
        wcnt = 0;
      end else begin
        if (rem_chk) chk("status_rem", {24'h0, bus.reg_rdata[15:8]}, 32'(writes_left()));
        if (bus.mst_req) begin
          started = 1;
          if (exp_q.size() == 0) begin
            bus.mst_ack = 1'b0;
            chk("unexpected_req", 32'(bus.mst_req), 32'd0);
          end else if (wcnt >= lat) begin
            chk("req_write", 32'(bus.mst_write), 32'(exp_q[0].wr));
            chk("req_addr", bus.mst_addr, exp_q[0].addr);
            chk("req_wstrb", 32'(bus.mst_wstrb), 32'hF);
            if (exp_q[0].wr) chk("req_wdata", bus.mst_wdata, exp_q[0].data);
            bus.mst_rdata = mem_word(bus.mst_addr);
            bus.mst_ack = 1'b1;
            wcnt = 0;
            n_acks++;
            void'(exp_q.pop_front());
          end else begin
            bus.mst_ack = 1'b0;
            wcnt++;
          end
        end else begin
          bus.mst_ack = 1'b0;
          wcnt = 0;
          if (gap_chk && started && exp_q.size() > 0) chk("req_gap", 32'(bus.mst_req), 32'd1);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic reg_wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.reg_we = 1'b1; bus.reg_addr = a; bus.reg_wdata = d;
    @(negedge clk);
    bus.reg_we = 1'b0;
  endtask

  task automatic reg_rd(input logic [4:0] a, output logic [31:0] d);
    bus.reg_addr = a;
    #1;
    d = bus.reg_rdata;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    chk("xfer_in_budget", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_acks(input int target, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (n_acks >= target) break;
    end
    chk("acks_in_budget", 32'(n_acks >= target), 32'd1);
  endtask

  task automatic setup(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
    reg_wr(5'h04, s);
    reg_wr(5'h08, d);
    reg_wr(5'h0C, n);
  endtask

  task automatic finish_irq();
    logic [31:0] v;
    chk("irq_not_early", 32'(bus.dma_irq), 32'd0);
    @(negedge clk); #1;
    chk("irq_after_last_ack", 32'(bus.dma_irq), 32'd1);
    chk("req_idle_in_done", 32'(bus.mst_req), 32'd0);
    reg_rd(5'h10, v);
    chk("status_done", v, 32'h0000_0002);
    reg_wr(5'h00, 32'h0);
    #1;
    chk("irq_cleared", 32'(bus.dma_irq), 32'd0);
    reg_rd(5'h10, v);
    chk("status_idle", v, 32'h0);
  endtask

  task automatic basic_copy();
    logic [31:0] v;
    lat = 2;
    plan(32'h1000, 32'h2000, 3);
    setup(32'h1000, 32'h2000, 32'd3);
    reg_rd(5'h04, v);
    chk("src_readback", v, 32'h1000);
    reg_wr(5'h00, 32'h1);
    #1;
    chk("req_not_on_start_edge", 32'(bus.mst_req), 32'd0);
    @(negedge clk); #1;
    chk("req_launch", 32'(bus.mst_req), 32'd1);
    reg_rd(5'h10, v);
    chk("status_busy", v, 32'h0000_0301);
    wait_done(100);
    finish_irq();
  endtask

  logic [31:0] v;

  initial begin
    bus.reg_we = 1'b0; bus.reg_addr = 5'h0; bus.reg_wdata = 32'h0;
    bus.mst_ack = 1'b0; bus.mst_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", 32'(bus.mst_req), 32'd0);
    chk("rst_write", 32'(bus.mst_write), 32'd0);
    chk("rst_addr", bus.mst_addr, 32'h0);
    chk("rst_wdata", bus.mst_wdata, 32'h0);
    chk("rst_irq", 32'(bus.dma_irq), 32'd0);
    for (int a = 0; a <= 16; a += 4) begin
      reg_rd(5'(a), v);
      chk("rst_reg", v, 32'h0);
    end
    reg_rd(5'h14, v);
    chk("unmapped_reads_0", v, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Pin the model against hand-derived transaction lists.
    plan(32'h1000, 32'h2000, 3);
    chk("model_n3_size", 32'(exp_q.size()), 32'd6);
    chk("model_n3_rd2", exp_q[2].addr, 32'h1008);
    chk("model_n3_wr0", {exp_q[3].wr, exp_q[3].addr[30:0]}, 32'h8000_2000);
    chk("model_n3_wdat", exp_q[5].data, mem_word(32'h1008));
    exp_q.delete();
    plan(32'h4000, 32'h8000, 10);
    chk("model_n10_size", 32'(exp_q.size()), 32'd20);
    chk("model_n10_w4", {exp_q[4].wr, exp_q[4].addr[30:0]}, 32'h8000_8000);
    chk("model_n10_r8", {exp_q[8].wr, exp_q[8].addr[30:0]}, 32'h0000_4010);
    chk("model_n10_r16", {exp_q[16].wr, exp_q[16].addr[30:0]}, 32'h0000_4020);
    chk("model_n10_w18", {exp_q[18].wr, exp_q[18].addr[30:0]}, 32'h8000_8020);
    exp_q.delete();

    basic_copy();

    // Multi-chunk with immediate acks: no gap on mst_req, rem steps down per write.
    lat = 0;
    plan(32'h4000, 32'h8000, 10);
    setup(32'h4000, 32'h8000, 32'd10);
    started = 0; gap_chk = 1;
    reg_wr(5'h00, 32'h1);
    reg_rd(5'h10, v);
    chk("status_start_rem10", v, 32'h0000_0A01);
    rem_chk = 1;
    wait_done(200);
    rem_chk = 0; gap_chk = 0;
    finish_irq();

    // Zero-length start, and EN=1 while in DONE is ignored.
    setup(32'h7000, 32'h7100, 32'd0);
    reg_wr(5'h00, 32'h1);
    #1;
    chk("len0_irq_c1", 32'(bus.dma_irq), 32'd0);
    @(negedge clk); #1;
    chk("len0_irq_c2", 32'(bus.dma_irq), 32'd1);
    reg_wr(5'h00, 32'h1);
    repeat (4) @(negedge clk);
    #1;
    chk("done_en1_ignored", 32'(bus.dma_irq), 32'd1);
    reg_rd(5'h10, v);
    chk("len0_status_done", v, 32'h0000_0002);
    reg_wr(5'h00, 32'h0);
    #1;
    chk("len0_irq_cleared", 32'(bus.dma_irq), 32'd0);
    reg_rd(5'h10, v);
    chk("len0_status_0", v, 32'h0);

    // SRC write while busy must not redirect the transfer.
    lat = 1;
    plan(32'h3000, 32'h6000, 6);
    setup(32'h3000, 32'h6000, 32'd6);
    reg_wr(5'h00, 32'h1);
    wait_acks(n_acks + 1, 50);
    reg_wr(5'h04, 32'h5000);
    reg_rd(5'h04, v);
    chk("src_protected", v, 32'h3000);
    reg_rd(5'h10, v);
    chk("status_busy_rd", {31'h0, v[0]}, 32'd1);
    wait_done(200);
    finish_irq();

`ifdef DMA_ABORT_EN
    lat = 2;
    plan(32'h9000, 32'hA000, 8);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    setup(32'h9000, 32'hA000, 32'd8);
    reg_wr(5'h00, 32'h1);
    wait_acks(n_acks + 1, 50);
    reg_wr(5'h00, 32'h0);
    wait_done(50);
    repeat (6) @(negedge clk);
    #1;
    chk("abort_no_req", 32'(bus.mst_req), 32'd0);
    chk("abort_irq_low", 32'(bus.dma_irq), 32'd0);
    reg_rd(5'h10, v);
    chk("abort_status", {29'h0, v[2:0]}, 32'h4);
`else
    // EN=0 mid-transfer is ignored; the copy still completes.
    lat = 2;
    plan(32'h9000, 32'hA000, 8);
    setup(32'h9000, 32'hA000, 32'd8);
    reg_wr(5'h00, 32'h1);
    wait_acks(n_acks + 1, 50);
    reg_wr(5'h00, 32'h0);
    reg_rd(5'h00, v);
    chk("ctrl_write_ignored", v, 32'h1);
    wait_done(300);
    finish_irq();
`endif

    // Async reset during the write phase.
    lat = 2;
    plan(32'h1000, 32'h2000, 3);
    setup(32'h1000, 32'h2000, 32'd3);
    reg_wr(5'h00, 32'h1);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (bus.mst_req && bus.mst_write) break;
    end
    chk("reached_wr", 32'(bus.mst_req && bus.mst_write), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_req_drop", 32'(bus.mst_req), 32'd0);
    chk("rst_mid_irq", 32'(bus.dma_irq), 32'd0);
    for (int a = 0; a <= 16; a += 4) begin
      reg_rd(5'(a), v);
      chk("rst_mid_reg", v, 32'h0);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    basic_copy();

    // Address wrap past all-ones, low address bits forced to zero.
    lat = 1;
    plan(32'hFFFF_FFFB, 32'h0000_0012, 5);
    chk("model_wrap_rd2", exp_q[2].addr, 32'h0);
    setup(32'hFFFF_FFFB, 32'h0000_0012, 32'd5);
    reg_rd(5'h04, v);
    chk("src_align", v, 32'hFFFF_FFF8);
    reg_rd(5'h08, v);
    chk("dst_align", v, 32'h0000_0010);
    reg_wr(5'h00, 32'h1);
    wait_done(200);
    finish_irq();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
